grf_wb_sched: RTL and testbench

Write-back scheduler and scoreboard for the 2-read/1-write general register file.
- Arbitrates NREQ write-back requesters (ALU, LSU, MUL/DIV) onto the single GRF write port with round-robin priority.
- Tracks pending destination registers and stalls issue on RAW/WAW hazards.
- Sits between the execute-side units and the GRF; its issue-stall output feeds the decode stage.

---
 rtl/core_grf_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/grf_wb_sched.sv | 146 ++++++++++++++
 tb/tb_grf_wb_sched.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_grf_pkg.sv
// Shared constants and types for the general register file write-back path.
package core_grf_pkg;

  localparam int AW   = 5;
  localparam int XLEN = 64;
  localparam int NREG = 32;

  typedef logic [AW-1:0] reg_idx_t;

  typedef struct packed {
    logic            valid;
    reg_idx_t        addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

  // True when the request vector has more than one bit set.
  function automatic logic multi_req(input logic [7:0] req);
    return (req & (req - 8'd1)) != 8'd0;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr_i and wraps.
module rr_arbiter #(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  // Two passes: the indices above the pointer first, then the wrap-around half.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid_o && req_i[i] && (i > int'(ptr_i))) begin
        grant_o[i] = 1'b1;
        idx_o      = PW'(i);
        valid_o    = 1'b1;
      end else begin
        valid_o = valid_o;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!valid_o && req_i[i] && (i <= int'(ptr_i))) begin
        grant_o[i] = 1'b1;
        idx_o      = PW'(i);
        valid_o    = 1'b1;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/grf_wb_sched.sv
// Write-back scheduler and RAW/WAW scoreboard in front of the single GRF write port.
module grf_wb_sched
  import core_grf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int XLEN = core_grf_pkg::XLEN,
  parameter int AW   = core_grf_pkg::AW
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rs1,
  input  logic [AW-1:0]        iss_rs2,
  input  logic [AW-1:0]        iss_rd,
  input  logic                 iss_rd_wen,
  output logic                 iss_stall,
  input  logic [NREQ-1:0]      wb_valid,
  input  logic [NREQ*AW-1:0]   wb_addr,
  input  logic [NREQ*XLEN-1:0] wb_data,
  output logic [NREQ-1:0]      wb_ready,
  output logic                 grf_wen,
  output logic [AW-1:0]        grf_waddr,
  output logic [XLEN-1:0]      grf_wdata,
  output logic                 sb_err,
  output logic [31:0]          conflict_cnt
);

  localparam int NR = 1 << AW;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] grant_s;
  logic [PW-1:0]   gidx_s;
  logic            transfer_s;
  logic [AW-1:0]   sel_addr_s;
  logic [XLEN-1:0] sel_data_s;
  logic            set_s;
  logic            conflict_s;

  logic [PW-1:0]   rr_ptr_q,  rr_ptr_d;
  logic [NR-1:0]   busy_q,    busy_d;
  logic            grf_wen_q, grf_wen_d;
  logic [AW-1:0]   waddr_q,   waddr_d;
  logic [XLEN-1:0] wdata_q,   wdata_d;
  logic            sb_err_q,  sb_err_d;
  logic [31:0]     cnt_q,     cnt_d;

  // A register is a hazard only while pending and not being written this cycle;
  // the GRF forwards the write to readers in the grf_wen cycle.
  function automatic logic hz(input logic [NR-1:0] busy, input logic wen,
                              input logic [AW-1:0] waddr, input logic [AW-1:0] r);
    return busy[r] && !(wen && (waddr == r));
  endfunction

  rr_arbiter #(.N(NREQ)) u_arb (
    .req_i   (wb_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant_s),
    .idx_o   (gidx_s),
    .valid_o (transfer_s)
  );

  assign wb_ready = grant_s;

  // One-hot AND-OR mux of the granted requester's address and data.
  always_comb begin
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_addr_s = sel_addr_s | ({AW{grant_s[i]}}   & wb_addr[i*AW +: AW]);
      sel_data_s = sel_data_s | ({XLEN{grant_s[i]}} & wb_data[i*XLEN +: XLEN]);
    end
  end

  assign iss_stall = iss_valid &&
                     (hz(busy_q, grf_wen_q, waddr_q, iss_rs1) ||
                      hz(busy_q, grf_wen_q, waddr_q, iss_rs2) ||
                      (iss_rd_wen && hz(busy_q, grf_wen_q, waddr_q, iss_rd)));

  assign set_s      = iss_valid && !iss_stall && iss_rd_wen && (iss_rd != '0);
  assign conflict_s = multi_req(8'(wb_valid));

  // Next-state: scoreboard (set after clear so set wins), output stage, counters.
  always_comb begin
    busy_d = busy_q;
    if (grf_wen_q) begin
      busy_d[waddr_q] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (set_s) begin
      busy_d[iss_rd] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;

    if (transfer_s) begin
      rr_ptr_d  = gidx_s;
      grf_wen_d = (sel_addr_s != '0);
      waddr_d   = sel_addr_s;
      wdata_d   = sel_data_s;
    end else begin
      rr_ptr_d  = rr_ptr_q;
      grf_wen_d = 1'b0;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
    end

    sb_err_d = sb_err_q ||
               (transfer_s && (sel_addr_s != '0) && !busy_q[sel_addr_s]);

    if (conflict_s && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset discards all pending scoreboard state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q  <= PW'(NREQ - 1);
      busy_q    <= '0;
      grf_wen_q <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      sb_err_q  <= 1'b0;
      cnt_q     <= 32'd0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      busy_q    <= busy_d;
      grf_wen_q <= grf_wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      sb_err_q  <= sb_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grf_wen      = grf_wen_q;
  assign grf_waddr    = waddr_q;
  assign grf_wdata    = wdata_q;
  assign sb_err       = sb_err_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_grf_wb_sched.sv
// Directed bench for grf_wb_sched with hand-computed expectations.
module tb_grf_wb_sched;

  localparam int NREQ = 3;
  localparam int XLEN = 64;
  localparam int AW   = 5;

  logic                 clock;
  logic                 reset;
  logic                 iss_valid;
  logic [AW-1:0]        iss_rs1;
  logic [AW-1:0]        iss_rs2;
  logic [AW-1:0]        iss_rd;
  logic                 iss_rd_wen;
  logic                 iss_stall;
  logic [NREQ-1:0]      wb_valid;
  logic [NREQ*AW-1:0]   wb_addr;
  logic [NREQ*XLEN-1:0] wb_data;
  logic [NREQ-1:0]      wb_ready;
  logic                 grf_wen;
  logic [AW-1:0]        grf_waddr;
  logic [XLEN-1:0]      grf_wdata;
  logic                 sb_err;
  logic [31:0]          conflict_cnt;

  int checks = 0;
  int errors = 0;

  grf_wb_sched #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clock        (clock),
    .reset        (reset),
    .iss_valid    (iss_valid),
    .iss_rs1      (iss_rs1),
    .iss_rs2      (iss_rs2),
    .iss_rd       (iss_rd),
    .iss_rd_wen   (iss_rd_wen),
    .iss_stall    (iss_stall),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .wb_ready     (wb_ready),
    .grf_wen      (grf_wen),
    .grf_waddr    (grf_waddr),
    .grf_wdata    (grf_wdata),
    .sb_err       (sb_err),
    .conflict_cnt (conflict_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic wen);
    iss_valid  = v;
    iss_rs1    = rs1;
    iss_rs2    = rs2;
    iss_rd     = rd;
    iss_rd_wen = wen;
  endtask

  task automatic wb_set(input int i, input logic v, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wb_valid[i]              = v;
    wb_addr[i*AW +: AW]      = a;
    wb_data[i*XLEN +: XLEN]  = d;
  endtask

  int          sent [NREQ];
  int          g;
  logic [2:0]  exp_gnt;
  logic [4:0]  exp_addr;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    wb_valid = '0;
    wb_addr  = '0;
    wb_data  = '0;
    tick();
    tick();
    check("rst_wen",   grf_wen, 1'b0);
    check("rst_waddr", grf_waddr, 5'd0);
    check("rst_wdata", grf_wdata, 64'd0);
    check("rst_sberr", sb_err, 1'b0);
    check("rst_cnt",   conflict_cnt, 32'd0);
    check("rst_ready", wb_ready, 3'b000);
    reset = 1'b1;
    tick();

    // RAW on x5 until requester 1 writes it back
    issue(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
    #1 check("t1_issue_rd5", iss_stall, 1'b0);
    tick();
    issue(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
    #1 check("t1_raw_stall", iss_stall, 1'b1);
    tick();
    check("t1_raw_stall2", iss_stall, 1'b1);
    wb_set(1, 1'b1, 5'd5, 64'hDEAD_BEEF_0000_0005);
    #1 check("t1_ready", wb_ready, 3'b010);
    tick();
    wb_set(1, 1'b0, 5'd0, 64'd0);
    check("t1_wen",   grf_wen, 1'b1);
    check("t1_waddr", grf_waddr, 5'd5);
    check("t1_wdata", grf_wdata, 64'hDEAD_BEEF_0000_0005);
    check("t1_fwd_nostall", iss_stall, 1'b0);
    tick();
    check("t1_wen_off", grf_wen, 1'b0);
    check("t1_cleared", iss_stall, 1'b0);
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    // fresh pointer, six pending registers x10..x15
    reset = 1'b0;
    #2 reset = 1'b1;
    for (int j = 0; j < 6; j++) begin
      issue(1'b1, 5'd0, 5'd0, 5'(10 + j), 1'b1);
      #1 check("t2_issue", iss_stall, 1'b0);
      tick();
    end
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    // all three requesters contend; each re-presents once after its grant
    for (int i = 0; i < NREQ; i++) sent[i] = 0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (sent[i] < 2) wb_set(i, 1'b1, 5'(10 + 3*sent[i] + i), 64'hA000 + 64'(10 + 3*sent[i] + i));
        else             wb_set(i, 1'b0, 5'd0, 64'd0);
      end
      g = k % 3;
      exp_gnt  = 3'b001 << g;
      exp_addr = 5'(10 + 3*sent[g] + g);
      #1 check("t2_grant", wb_ready, exp_gnt);
      tick();
      check("t2_wen",   grf_wen, 1'b1);
      check("t2_waddr", grf_waddr, exp_addr);
      check("t2_wdata", grf_wdata, 64'hA000 + 64'(exp_addr));
      sent[g] = sent[g] + 1;
    end
    wb_valid = '0;
    check("t2_conflict_cnt", conflict_cnt, 32'd5);
    check("t2_sberr", sb_err, 1'b0);

    // issue of rd=7 in the cycle x7 is written back: no stall, set wins
    issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
    #1 check("t3_issue_rd7", iss_stall, 1'b0);
    tick();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    wb_set(0, 1'b1, 5'd7, 64'h7777);
    #1 check("t3_ready", wb_ready, 3'b001);
    tick();
    wb_set(0, 1'b0, 5'd0, 64'd0);
    check("t3_wen", grf_wen, 1'b1);
    issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
    #1 check("t3_same_cycle", iss_stall, 1'b0);
    tick();
    issue(1'b1, 5'd7, 5'd0, 5'd0, 1'b0);
    #1 check("t3_set_wins", iss_stall, 1'b1);
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    wb_set(1, 1'b1, 5'd7, 64'h7778);
    #1 check("t3_ready2", wb_ready, 3'b010);
    tick();
    wb_set(1, 1'b0, 5'd0, 64'd0);
    tick();
    issue(1'b1, 5'd7, 5'd0, 5'd0, 1'b0);
    #1 check("t3_cleared", iss_stall, 1'b0);
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    // x0 never stalls and its write-back is dropped
    issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    #1 check("t4_x0_issue", iss_stall, 1'b0);
    tick();
    #1 check("t4_x0_again", iss_stall, 1'b0);
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    wb_set(1, 1'b1, 5'd0, 64'h1234);
    #1 check("t4_ready", wb_ready, 3'b010);
    tick();
    wb_set(1, 1'b0, 5'd0, 64'd0);
    check("t4_wen", grf_wen, 1'b0);
    check("t4_sberr", sb_err, 1'b0);

    // write-back to non-pending x9: accepted, sticky sb_err
    wb_set(2, 1'b1, 5'd9, 64'h9999);
    #1 check("t5_ready", wb_ready, 3'b100);
    tick();
    wb_set(2, 1'b0, 5'd0, 64'd0);
    check("t5_wen",   grf_wen, 1'b1);
    check("t5_waddr", grf_waddr, 5'd9);
    check("t5_wdata", grf_wdata, 64'h9999);
    check("t5_sberr", sb_err, 1'b1);
    tick();
    tick();
    check("t5_sberr_sticky", sb_err, 1'b1);
    check("t5_wen_off", grf_wen, 1'b0);

    // asynchronous reset mid-burst with x3, x4 pending
    issue(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
    tick();
    issue(1'b1, 5'd0, 5'd0, 5'd4, 1'b1);
    tick();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    wb_set(0, 1'b1, 5'd3, 64'h3333);
    wb_set(1, 1'b1, 5'd4, 64'h4444);
    #1 check("t6_ready", wb_ready, 3'b001);
    tick();
    wb_set(0, 1'b0, 5'd0, 64'd0);
    check("t6_wen_pre", grf_wen, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_wen",   grf_wen, 1'b0);
    check("t6_rst_waddr", grf_waddr, 5'd0);
    check("t6_rst_wdata", grf_wdata, 64'd0);
    check("t6_rst_sberr", sb_err, 1'b0);
    check("t6_rst_cnt",   conflict_cnt, 32'd0);
    issue(1'b1, 5'd3, 5'd4, 5'd0, 1'b0);
    wb_set(0, 1'b1, 5'd3, 64'h3333);
    wb_set(2, 1'b1, 5'd0, 64'h0);
    #1 check("t6_busy_clear", iss_stall, 1'b0);
    check("t6_rst_ready", wb_ready, 3'b001);
    reset = 1'b1;
    #1 check("t6_first_grant", wb_ready, 3'b001);
    wb_valid = '0;
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
